knn_query_ctrl: RTL and testbench
=================================

Name: knn_query_ctrl

Overview:
- Transmitter and reader at the two ends of the kNN insertion-sort chain.
- Accepts one query's stream of (distance, label) samples from the distance unit over valid/ready, tags each sample with a sequential index, and drives the chain head.
- Waits for the chain to settle, then reads the K per-stage nearest-neighbor labels and computes the majority-vote class.
- Sits between the distance unit and the classifier result register.

Parameters:
DIST_W, 16, distance width; equal to the chain's distance width
K, 8, number of chain stages (neighbors); 1..15
VOTE_W, 4, vote-count width; must satisfy 2^VOTE_W > K

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a query; honored only in IDLE or DONE
num_samples  in  8  samples in the query, latched at start; 0 means 256
s_valid  in  1  sample valid
s_ready  out  1  sample ready
s_dist  in  DIST_W  sample distance
s_label  in  2  sample class label
chain_rst  out  1  active-high synchronous clear to the chain
chain_dist  out  DIST_W  distance into chain stage 0 (registered)
chain_label  out  2  label into chain stage 0 (registered)
chain_index  out  8  index into chain stage 0 (registered)
nn_labels  in  2*K  per-stage label_nn, stage i at bits [2i+1:2i]; stage 0 is nearest
busy  out  1  high in CLR, STREAM, DRAIN, VOTE, DECIDE
done  out  1  one-cycle pulse; result valid
class_out  out  2  voted class; held until the next start
class_votes  out  VOTE_W  vote count of class_out; held with class_out

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - s_ready, done, busy, class_out, class_votes, chain_label and chain_index go to 0.
  - chain_dist goes to all-ones.
  - chain_rst is high whenever rst_n is low; this is the only combinational path.
  - Reset mid-query aborts the query with no done pulse.
- Bubble: in every cycle without a handshake, chain_dist/label/index register all-ones/0/0.
- States: IDLE, CLR, STREAM, DRAIN, VOTE, DECIDE, DONE.
- IDLE/DONE: s_ready=0. On start: latch N (0→256), clear the index counter and the 4 vote counters, go to CLR. start in any other state is ignored.
- CLR (1 cycle): chain_rst=1, then go to STREAM.
- STREAM: s_ready=1.
  - A handshake (s_valid & s_ready) registers {s_dist, s_label, idx} onto the chain outputs next edge, then idx++.
  - s_valid low inserts a bubble; the index does not advance.
  - On the handshake with idx==N-1: s_ready drops next cycle and the state goes to DRAIN.
- DRAIN: exactly K+1 cycles (output register plus K stages), bubbles only; then go to VOTE.
- VOTE: K cycles. Cycle j reads stage j's label from nn_labels and increments that label's counter.
- DECIDE (1 cycle):
  - class_out is the label with the maximum count; a tie goes to the lowest label value.
  - class_votes is that count.
- DONE: done=1 for the first cycle only. Then hold in DONE, with outputs held, until start.
- Latency: if the last handshake occurs at edge t, done is high during the cycle after edge t+2K+3.
- The index wraps only past 255; N=256 uses indices 0..255.
- Counters are VOTE_W bits and cannot overflow since K < 2^VOTE_W.

Test Plan:
- Reset, then start with N=3 and K=4; samples arrive with s_valid held high.
  - After CLR, chain_rst pulses for exactly 1 cycle.
  - The chain head shows indices 0, 1, 2 on consecutive cycles.
  - s_ready falls after the 3rd handshake.
- K=4, N=4, s_valid toggling 1,0,1,0,... → a bubble (all-ones, 0, 0) is inserted on each low cycle and indices stay contiguous 0..3.
- K=4 with nn_labels stages 0..3 = 2,1,2,3 → class_out=2, class_votes=2.
  - done fires exactly 2K+3=11 edges after the last handshake.
- K=4 with nn_labels = 3,1,3,1 (tie) → class_out=1, class_votes=2.
- rst_n low for 1 cycle during DRAIN.
  - No done pulse; all outputs return to reset values; chain_rst is high during reset.
  - A following start with N=1 completes normally.
- start pulsed during STREAM has no effect.
- After done, class_out stays held.
- A second start with num_samples=0 accepts 256 samples with indices 0..255.

Source files
------------

// File: rtl/knn_query_ctrl.sv
// knn_query_ctrl: feeds one query's (distance, label) stream into the head of the
// kNN insertion-sort chain, waits for the chain to settle, then reads the K
// nearest labels back and produces the majority-vote class.
module knn_query_ctrl #(
   parameter int unsigned DIST_W = 16,
   parameter int unsigned K      = 8,
   parameter int unsigned VOTE_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [7:0]          num_samples,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DIST_W-1:0]   s_dist,
   input  logic [1:0]          s_label,
   output logic                chain_rst,
   output logic [DIST_W-1:0]   chain_dist,
   output logic [1:0]          chain_label,
   output logic [7:0]          chain_index,
   input  logic [2*K-1:0]      nn_labels,
   output logic                busy,
   output logic                done,
   output logic [1:0]          class_out,
   output logic [VOTE_W-1:0]   class_votes
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_STREAM,
      ST_DRAIN,
      ST_VOTE,
      ST_DECIDE,
      ST_DONE
   } state_t;

   localparam logic [3:0]        DRAIN_LAST = 4'(K);
   localparam logic [3:0]        VOTE_LAST  = 4'(K - 1);
   localparam logic [VOTE_W-1:0] VOTE_ONE   = VOTE_W'(1);

   state_t              r_state;
   logic [8:0]          r_n;
   logic [7:0]          r_idx;
   logic [3:0]          r_dcnt;
   logic [3:0]          r_vidx;
   logic [VOTE_W-1:0]   r_cnt [4];
   logic [1:0]          r_win_lbl;
   logic [VOTE_W-1:0]   r_win_cnt;
   logic                r_out_pend;
   logic                r_s_ready;
   logic                r_chain_rst;
   logic [DIST_W-1:0]   r_chain_dist;
   logic [1:0]          r_chain_label;
   logic [7:0]          r_chain_index;
   logic                r_busy;
   logic                r_done;
   logic [1:0]          r_class;
   logic [VOTE_W-1:0]   r_votes;

   logic                w_hs;
   logic                w_last;
   logic [1:0]          w_vote_lbl;
   logic [1:0]          w_best_lbl;
   logic [VOTE_W-1:0]   w_best_cnt;

   assign w_hs   = s_valid & r_s_ready;
   assign w_last = ({1'b0, r_idx} == (r_n - 9'd1));

   assign s_ready     = r_s_ready;
   assign chain_rst   = r_chain_rst | ~rst_n;
   assign chain_dist  = r_chain_dist;
   assign chain_label = r_chain_label;
   assign chain_index = r_chain_index;
   assign busy        = r_busy;
   assign done        = r_done;
   assign class_out   = r_class;
   assign class_votes = r_votes;

   // select the label of the chain stage currently being tallied
   always_comb begin
      w_vote_lbl = '0;
      for (int unsigned i = 0; i < K; i++) begin
         if (r_vidx == 4'(i)) w_vote_lbl = nn_labels[2*i +: 2];
      end
   end

   // majority pick; strict compare keeps the lowest label on a tie
   always_comb begin
      w_best_lbl = '0;
      w_best_cnt = r_cnt[0];
      for (int unsigned i = 1; i < 4; i++) begin
         if (r_cnt[i] > w_best_cnt) begin
            w_best_cnt = r_cnt[i];
            w_best_lbl = 2'(i);
         end
      end
   end

   // control FSM, chain-head register and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_n           <= '0;
         r_idx         <= '0;
         r_dcnt        <= '0;
         r_vidx        <= '0;
         for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
         r_win_lbl     <= '0;
         r_win_cnt     <= '0;
         r_out_pend    <= 1'b0;
         r_s_ready     <= 1'b0;
         r_chain_rst   <= 1'b0;
         r_chain_dist  <= '1;
         r_chain_label <= '0;
         r_chain_index <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_class       <= '0;
         r_votes       <= '0;
      end else begin
         // chain head carries a bubble unless a sample is accepted this edge
         r_chain_dist  <= '1;
         r_chain_label <= '0;
         r_chain_index <= '0;
         r_chain_rst   <= 1'b0;
         r_done        <= 1'b0;
         if (w_hs) begin
            r_chain_dist  <= s_dist;
            r_chain_label <= s_label;
            r_chain_index <= r_idx;
         end

         // decision is staged one cycle before it is published with done
         if (r_out_pend) begin
            r_class    <= r_win_lbl;
            r_votes    <= r_win_cnt;
            r_done     <= 1'b1;
            r_out_pend <= 1'b0;
         end

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_n         <= (num_samples == 8'd0) ? 9'd256 : {1'b0, num_samples};
                  r_idx       <= '0;
                  for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
                  r_chain_rst <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ST_CLR;
               end
            end
            ST_CLR: begin
               r_s_ready <= 1'b1;
               r_state   <= ST_STREAM;
            end
            ST_STREAM: begin
               if (w_hs) begin
                  r_idx <= r_idx + 8'd1;
                  if (w_last) begin
                     r_s_ready <= 1'b0;
                     r_dcnt    <= '0;
                     r_state   <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_dcnt == DRAIN_LAST) begin
                  r_vidx  <= '0;
                  r_state <= ST_VOTE;
               end else begin
                  r_dcnt <= r_dcnt + 4'd1;
               end
            end
            ST_VOTE: begin
               r_cnt[w_vote_lbl] <= r_cnt[w_vote_lbl] + VOTE_ONE;
               if (r_vidx == VOTE_LAST) r_state <= ST_DECIDE;
               else                     r_vidx  <= r_vidx + 4'd1;
            end
            ST_DECIDE: begin
               r_win_lbl  <= w_best_lbl;
               r_win_cnt  <= w_best_cnt;
               r_out_pend <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= ST_DONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_knn_query_ctrl.sv
// tb_knn_query_ctrl: scoreboard bench for knn_query_ctrl (K=4).
module tb_knn_query_ctrl;

   localparam int DIST_W = 16;
   localparam int K      = 4;
   localparam int VOTE_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        num_samples = '0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DIST_W-1:0] s_dist = '0;
   logic [1:0]        s_label = '0;
   logic              chain_rst;
   logic [DIST_W-1:0] chain_dist;
   logic [1:0]        chain_label;
   logic [7:0]        chain_index;
   logic [2*K-1:0]    nn_labels = '0;
   logic              busy;
   logic              done;
   logic [1:0]        class_out;
   logic [VOTE_W-1:0] class_votes;

   knn_query_ctrl #(.DIST_W(DIST_W), .K(K), .VOTE_W(VOTE_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .s_valid(s_valid), .s_ready(s_ready), .s_dist(s_dist), .s_label(s_label),
      .chain_rst(chain_rst), .chain_dist(chain_dist), .chain_label(chain_label),
      .chain_index(chain_index), .nn_labels(nn_labels), .busy(busy), .done(done),
      .class_out(class_out), .class_votes(class_votes)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_hs  = 0;
   int rem      = 0;
   int crst_cnt = 0;
   int done_cnt = 0;
   logic [25:0] q_chain [$];
   logic [5:0]  q_res [$];
   logic [5:0]  last_res = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pack4(input int a, input int b, input int c, input int d);
      logic [1:0] s0, s1, s2, s3;
      s0 = 2'(a); s1 = 2'(b); s2 = 2'(c); s3 = 2'(d);
      return {s3, s2, s1, s0};
   endfunction

   // reference vote: {label[1:0], votes[3:0]}
   function automatic logic [5:0] model_vote(input logic [7:0] nn);
      int c [4];
      int best;
      logic [1:0] l;
      for (int i = 0; i < 4; i++) c[i] = 0;
      for (int s = 0; s < K; s++) begin
         l = nn[2*s +: 2];
         c[l]++;
      end
      best = 0;
      for (int i = 1; i < 4; i++) if (c[i] > c[best]) best = i;
      return {2'(best), 4'(c[best])};
   endfunction

   // monitor: chain head, ready, chain_rst length, done/result, latency
   always @(posedge clk) begin
      logic hs;
      logic [25:0] e;
      logic [5:0]  r;
      hs = s_valid && s_ready && rst_n;
      cyc++;
      #1;
      if (hs) begin
         check_eq("chain_q_nonempty", 32'(q_chain.size() > 0), 1);
         if (q_chain.size() > 0) begin
            e = q_chain.pop_front();
            check_eq("chain_head", {chain_dist, chain_label, chain_index}, e);
         end
         last_hs = cyc;
         rem--;
         check_eq("s_ready_after_hs", s_ready, (rem == 0) ? 1'b0 : 1'b1);
      end else begin
         check_eq("chain_bubble", {chain_dist, chain_label, chain_index}, {16'hffff, 2'd0, 8'd0});
      end
      if (rst_n && chain_rst) crst_cnt++;
      if (done) begin
         done_cnt++;
         check_eq("res_q_nonempty", 32'(q_res.size() > 0), 1);
         if (q_res.size() > 0) begin
            r = q_res.pop_front();
            last_res = r;
            check_eq("class_out", class_out, r[5:4]);
            check_eq("class_votes", class_votes, r[3:0]);
         end
         check_eq("done_latency", cyc - last_hs, 2*K + 3);
         check_eq("chain_rst_len", crst_cnt, 1);
      end
   end

   task automatic start_query(input logic [7:0] n, input logic [7:0] nn);
      @(negedge clk);
      nn_labels = nn;
      rem = (n == 8'd0) ? 256 : int'(n);
      crst_cnt = 0;
      q_res.push_back(model_vote(nn));
      start = 1'b1;
      num_samples = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_samples(input int n, input bit toggle, input bit poke);
      int  sent = 0;
      int  guard = 0;
      bit  skip = 0;
      bit  need_new = 1;
      while (sent < n && guard < 2000) begin
         @(negedge clk);
         guard++;
         start = 1'b0;
         if (poke && guard == 3) begin
            start = 1'b1;
            num_samples = 8'd7;
         end
         if (skip) begin
            s_valid = 1'b0;
            skip = 0;
         end else begin
            if (need_new) begin
               s_dist  = 16'($urandom_range(0, 16'hfffe));
               s_label = 2'($urandom_range(0, 3));
               need_new = 0;
            end
            s_valid = 1'b1;
            if (s_ready) begin
               q_chain.push_back({s_dist, s_label, sent[7:0]});
               sent++;
               need_new = 1;
               skip = toggle;
            end
         end
      end
      check_eq("send_in_budget", 32'(sent == n), 1);
      @(negedge clk);
      s_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int d0 = done_cnt;
      int guard = 0;
      while (done_cnt == d0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check_eq("done_seen", 32'(done_cnt > d0), 1);
      @(negedge clk);
      check_eq("done_one_cycle", done, 1'b0);
      check_eq("busy_after_done", busy, 1'b0);
   endtask

   task automatic check_reset_vals();
      check_eq("rst_s_ready", s_ready, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_class", class_out, 2'd0);
      check_eq("rst_votes", class_votes, 4'd0);
      check_eq("rst_chain_rst", chain_rst, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0;
      // power-on reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_s_ready", s_ready, 1'b0);
      check_eq("idle_chain_rst", chain_rst, 1'b0);

      // N=3, valid held high, labels 2,1,2,3
      start_query(8'd3, pack4(2, 1, 2, 3));
      check_eq("busy_in_clr", busy, 1'b1);
      send_samples(3, 1'b0, 1'b0);
      wait_done();

      // N=4, valid toggling, tie 3,1,3,1
      start_query(8'd4, pack4(3, 1, 3, 1));
      send_samples(4, 1'b1, 1'b0);
      wait_done();

      // start pulsed mid-stream is ignored
      start_query(8'd5, pack4(0, 3, 3, 0));
      send_samples(5, 1'b0, 1'b1);
      wait_done();

      // result held while idle in DONE
      repeat (5) @(negedge clk);
      check_eq("held_class", class_out, last_res[5:4]);
      check_eq("held_votes", class_votes, last_res[3:0]);

      // reset during DRAIN aborts the query
      start_query(8'd2, pack4(1, 1, 2, 0));
      send_samples(2, 1'b0, 1'b0);
      check_eq("busy_drain", busy, 1'b1);
      void'(q_res.pop_front());
      d0 = done_cnt;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check_eq("abort_no_done", done_cnt, d0);

      // N=1 after abort
      start_query(8'd1, pack4(3, 2, 2, 1));
      send_samples(1, 1'b0, 1'b0);
      wait_done();

      // N=0 means 256 samples, indices 0..255
      start_query(8'd0, pack4($urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 3)));
      send_samples(256, 1'b0, 1'b0);
      wait_done();
      check_eq("chain_q_drained", q_chain.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
